// File: rtl/switch_bank_pkg.sv
// Shared constants and sizing helpers for the switch bank sampler.
package switch_bank_pkg;

   localparam int SYNC_DEPTH = 2;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   function automatic int cnt_width(input int cycles);
      return clog2(cycles) + 1;
   endfunction

endpackage

// File: rtl/switch_bank_sampler_debounce_ch.sv
// One switch channel: pin synchronizer, stability counter,
// debounced value and registered edge pulses.
module debounce_ch
   import switch_bank_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic rst_val,
   input  logic sw,
   output logic val,
   output logic rise,
   output logic fall,
   output logic flip,
   output logic val_nxt
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_DEPTH-1:0] sync_q;
   logic [CW-1:0]         cnt;
   logic                  synced;
   logic                  differ;

   assign synced  = sync_q[SYNC_DEPTH-1];
   assign differ  = synced ^ val;
   assign flip    = differ && (cnt == CNT_MAX);
   assign val_nxt = val ^ flip;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {SYNC_DEPTH{rst_val}};
      end else begin
         sync_q <= {sync_q[SYNC_DEPTH-2:0], sw};
      end
   end

   // Any return to agreement restarts the stability count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!differ || flip) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val  <= rst_val;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         val  <= val_nxt;
         rise <= val_nxt & ~val;
         fall <= ~val_nxt & val;
      end
   end

endmodule

// File: rtl/switch_bank_sampler.sv
// Debounced switch bank with a single-entry change-event register
// and sticky overwrite flag.
module switch_bank_sampler
   import switch_bank_pkg::*;
#(
   parameter int               WIDTH           = 4,
   parameter int               DEBOUNCE_CYCLES = 4,
   parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_in,
   output logic [WIDTH-1:0] val,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [WIDTH-1:0] evt_val,
   output logic             evt_ovf,
   input  logic             ovf_clr
);

   logic [WIDTH-1:0] flip;
   logic [WIDTH-1:0] val_nxt;
   logic             any_flip;
   logic             ovf_set;

   debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_ch[WIDTH-1:0] (
      .clk    (clk),
      .rst_n  (rst_n),
      .rst_val(RESET_VAL),
      .sw     (sw_in),
      .val    (val),
      .rise   (rise),
      .fall   (fall),
      .flip   (flip),
      .val_nxt(val_nxt)
   );

   assign any_flip = |flip;
   assign ovf_set  = evt_valid && !evt_ready && any_flip;

   // A fresh flip always wins over a same-cycle accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_valid <= 1'b0;
         evt_val   <= RESET_VAL;
      end else if (any_flip) begin
         evt_valid <= 1'b1;
         evt_val   <= val_nxt;
      end else if (evt_ready) begin
         evt_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_ovf <= 1'b0;
      end else if (ovf_set) begin
         evt_ovf <= 1'b1;
      end else if (ovf_clr) begin
         evt_ovf <= 1'b0;
      end
   end

endmodule
